// File: rtl/ac_stack.sv
// Accumulator register with carry/zero flags and a DEPTH-entry save/restore LIFO.
// Every output is registered; all ops take effect on the rising edge after they are sampled.
module ac_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Data_in,
    output logic [WIDTH-1:0] Data_out,
    output logic             carry,
    output logic             zero,
    output logic [CNT_W-1:0] depth_cnt,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OpNop   = 3'b000,
        OpLoad  = 3'b001,
        OpClear = 3'b010,
        OpInc   = 3'b011,
        OpAdd   = 3'b100,
        OpPush  = 3'b101,
        OpPop   = 3'b110,
        OpSwap  = 3'b111
    } op_e;

    logic [WIDTH-1:0] ac_q, ac_d;
    logic             carry_q, carry_d;
    logic             zero_q;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic             full_w, empty_w;
    logic [IDX_W-1:0] push_idx, top_idx;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   sum;
    logic             stack_we;
    logic [IDX_W-1:0] stack_widx;

    assign full_w   = (cnt_q == CNT_W'(DEPTH));
    assign empty_w  = (cnt_q == '0);
    assign push_idx = IDX_W'(cnt_q);
    assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));
    assign operand  = (op_e'(op) == OpInc) ? WIDTH'(1) : Data_in;
    assign sum      = {1'b0, ac_q} + {1'b0, operand};

    always_comb begin
        ac_d       = ac_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        stack_we   = 1'b0;
        stack_widx = push_idx;
        if (en) begin
            unique case (op_e'(op))
                OpNop:   ;
                OpLoad:  ac_d = Data_in;
                OpClear: begin
                    ac_d    = '0;
                    carry_d = 1'b0;
                end
                OpInc, OpAdd: {carry_d, ac_d} = sum;
                OpPush: begin
                    if (full_w) begin
                        err_d = 1'b1;
                    end else begin
                        stack_we = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
                OpPop: begin
                    if (empty_w) begin
                        err_d = 1'b1;
                    end else begin
                        ac_d  = stack_q[top_idx];
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                OpSwap: begin
                    if (empty_w) begin
                        err_d = 1'b1;
                    end else begin
                        ac_d       = stack_q[top_idx];
                        stack_we   = 1'b1;
                        stack_widx = top_idx;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ac_q    <= ac_d;
            carry_q <= carry_d;
            zero_q  <= (ac_d == '0);
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; depth_cnt alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && stack_we) begin
            stack_q[stack_widx] <= ac_q;
        end
    end

    assign Data_out  = ac_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign depth_cnt = cnt_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign err       = err_q;

endmodule

// File: tb/tb_ac_stack.sv
// Scoreboard bench for ac_stack: stimulus pushes model predictions, a monitor pops and compares.
module tb_ac_stack;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic [2:0]   op;
    logic [W-1:0] Data_in;
    logic [W-1:0] Data_out;
    logic         carry;
    logic         zero;
    logic [2:0]   depth_cnt;
    logic         full;
    logic         empty;
    logic         err;

    ac_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .Data_in   (Data_in),
        .Data_out  (Data_out),
        .carry     (carry),
        .zero      (zero),
        .depth_cnt (depth_cnt),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int ac;
        bit carry;
        bit zero;
        int cnt;
        bit full;
        bit empty;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   step_id = 0;

    // Reference model: plain integers and a queue as the LIFO.
    int m_ac = 0;
    bit m_carry = 0;
    int m_stk[$];

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s step %0d: got %0h want %0h", name, id, act, expv);
        end
    endtask

    task automatic step(input bit r, input bit e, input int o, input int d);
        exp_t x;
        bit   m_err;
        int   s;
        int   t;
        @(negedge clk);
        rst = r; en = e; op = 3'(o); Data_in = W'(d);
        m_err = 0;
        if (r) begin
            m_ac = 0; m_carry = 0; m_stk.delete();
        end else if (e) begin
            case (o)
                1: m_ac = d;
                2: begin m_ac = 0; m_carry = 0; end
                3, 4: begin
                    s = m_ac + ((o == 3) ? 1 : d);
                    m_carry = (s >= (1 << W));
                    m_ac = s % (1 << W);
                end
                5: if (m_stk.size() == D) m_err = 1; else m_stk.push_back(m_ac);
                6: if (m_stk.size() == 0) m_err = 1; else m_ac = m_stk.pop_back();
                7: if (m_stk.size() == 0) m_err = 1;
                   else begin
                       t = m_stk[m_stk.size() - 1];
                       m_stk[m_stk.size() - 1] = m_ac;
                       m_ac = t;
                   end
                default: ;
            endcase
        end
        x.id = step_id++;
        x.ac = m_ac;
        x.carry = m_carry;
        x.zero = (m_ac == 0);
        x.cnt = m_stk.size();
        x.full = (m_stk.size() == D);
        x.empty = (m_stk.size() == 0);
        x.err = m_err;
        exp_q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("data_out", x.id, 32'(Data_out), 32'(x.ac));
            chk("carry", x.id, 32'(carry), 32'(x.carry));
            chk("zero", x.id, 32'(zero), 32'(x.zero));
            chk("depth_cnt", x.id, 32'(depth_cnt), 32'(x.cnt));
            chk("full", x.id, 32'(full), 32'(x.full));
            chk("empty", x.id, 32'(empty), 32'(x.empty));
            chk("err", x.id, 32'(err), 32'(x.err));
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; op = 3'd0; Data_in = '0;
        // Reset, idle, then en=0 with a LOAD presented.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 8'h55);
        // Arithmetic and wrap-around.
        step(0, 1, 1, 8'hFE);
        step(0, 1, 3, 0);
        step(0, 1, 3, 0);
        step(0, 1, 4, 8'h10);
        step(0, 1, 4, 8'hF5);
        step(0, 1, 2, 0);
        // Fill the stack, then overflow.
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 1, i * 8'h11);
            step(0, 1, 5, 0);
        end
        step(0, 1, 5, 0);
        step(0, 1, 0, 0);
        // Drain, then underflow.
        for (int i = 0; i < 5; i++) step(0, 1, 6, 0);
        step(0, 1, 0, 0);
        // Swap behaviour and swap on an empty stack.
        step(0, 1, 1, 8'hAA);
        step(0, 1, 5, 0);
        step(0, 1, 1, 8'h0F);
        step(0, 1, 7, 0);
        step(0, 1, 6, 0);
        step(0, 1, 7, 0);
        step(0, 1, 0, 0);
        // Reset with a PUSH pending, then POP on the emptied stack.
        for (int i = 0; i < 3; i++) step(0, 1, 5, 0);
        step(1, 1, 5, 0);
        step(0, 1, 6, 0);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
        end
        @(negedge clk);
        en = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
